// File: rtl/ysyx_22051013_fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, buffered hand-off to decode.
// Define YSYX_22051013_FETCH_SKID_EN for a two-entry buffer that keeps fetching while decode stalls.
module ysyx_22051013_fetch_ctrl #(
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  input  logic [PC_W-1:0]   bpu_pc_i,
  output logic [PC_W-1:0]   fetch_pc_o,
  output logic              ireq_valid_o,
  output logic [PC_W-1:0]   ireq_addr_o,
  input  logic              ireq_ready_i,
  input  logic              iresp_valid_i,
  input  logic [INST_W-1:0] iresp_inst_i,
  output logic              if_valid_o,
  output logic [PC_W-1:0]   if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  input  logic              id_ready_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

`ifdef YSYX_22051013_FETCH_SKID_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [PC_W-1:0]   fetch_pc;
  logic [PC_W-1:0]   fetch_pc_nxt;
  logic [PC_W-1:0]   pend_pc;
  logic [PC_W-1:0]   pend_pc_nxt;
  logic              drop;
  logic              drop_nxt;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nxt;
  logic              push;
  logic              pop;
  logic [PC_W-1:0]   head_pc;
  logic [INST_W-1:0] head_inst;

  // A redirect cycle never transfers, so stale instructions cannot slip into decode.
  assign if_valid_o = (cnt != 2'd0) && !redirect_i;
  assign pop        = if_valid_o && id_ready_i;
  assign push       = (state == WAIT) && iresp_valid_i && !redirect_i && !drop;
  assign fetch_pc_o = fetch_pc;
  assign if_pc_o    = head_pc;
  assign if_inst_o  = head_inst;

  // Buffer occupancy: redirect flushes, otherwise net of push and pop.
  always_comb begin
    cnt_nxt = cnt;
    if (redirect_i) begin
      cnt_nxt = 2'd0;
    end else begin
      cnt_nxt = cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Next-state logic; a redirect during an outstanding request is parked until the response returns.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    pend_pc_nxt  = pend_pc;
    drop_nxt     = drop;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc_i;
        end else begin
          fetch_pc_nxt = fetch_pc;
        end
      end
      REQ: begin
        if (redirect_i) begin
          pend_pc_nxt = redirect_pc_i;
          drop_nxt    = 1'b1;
        end else begin
          pend_pc_nxt = pend_pc;
        end
        if (ireq_ready_i) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = REQ;
        end
      end
      WAIT: begin
        if (iresp_valid_i) begin
          if (redirect_i) begin
            fetch_pc_nxt = redirect_pc_i;
            drop_nxt     = 1'b0;
            state_nxt    = REQ;
          end else if (drop) begin
            fetch_pc_nxt = pend_pc;
            drop_nxt     = 1'b0;
            state_nxt    = REQ;
          end else begin
            fetch_pc_nxt = bpu_pc_i;
            state_nxt    = (cnt_nxt == DEPTH) ? HOLD : REQ;
          end
        end else if (redirect_i) begin
          pend_pc_nxt = redirect_pc_i;
          drop_nxt    = 1'b1;
          state_nxt   = WAIT;
        end else begin
          state_nxt = WAIT;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          fetch_pc_nxt = redirect_pc_i;
          state_nxt    = REQ;
        end else if (pop) begin
          state_nxt = REQ;
        end else begin
          state_nxt = HOLD;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= {PC_W{1'b0}};
      drop     <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      pend_pc  <= pend_pc_nxt;
      drop     <= drop_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Request port registered from next state, so address and valid stay stable in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ireq_valid_o <= 1'b0;
      ireq_addr_o  <= RESET_PC;
    end else begin
      ireq_valid_o <= (state_nxt == REQ);
      ireq_addr_o  <= fetch_pc_nxt;
    end
  end

`ifdef YSYX_22051013_FETCH_SKID_EN
  logic [PC_W-1:0]   tail_pc;
  logic [INST_W-1:0] tail_inst;

  // Two-entry in-order buffer: head feeds decode, tail shifts forward on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_pc   <= {PC_W{1'b0}};
      head_inst <= {INST_W{1'b0}};
      tail_pc   <= {PC_W{1'b0}};
      tail_inst <= {INST_W{1'b0}};
    end else begin
      if (pop && (cnt == 2'd2)) begin
        head_pc   <= tail_pc;
        head_inst <= tail_inst;
      end else if (push && ((cnt == 2'd0) || pop)) begin
        head_pc   <= fetch_pc;
        head_inst <= iresp_inst_i;
      end
      if (push && ((cnt == 2'd2) || ((cnt == 2'd1) && !pop))) begin
        tail_pc   <= fetch_pc;
        tail_inst <= iresp_inst_i;
      end
    end
  end
`else
  // Single-entry buffer; contents hold while decode stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_pc   <= {PC_W{1'b0}};
      head_inst <= {INST_W{1'b0}};
    end else if (push) begin
      head_pc   <= fetch_pc;
      head_inst <= iresp_inst_i;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22051013_fetch_ctrl.sv
// Table-driven bench for ysyx_22051013_fetch_ctrl, plus an asynchronous-reset sequence.
module tb_ysyx_22051013_fetch_ctrl;

  localparam logic [63:0] P = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic [63:0] bpu_pc_i;
  logic [63:0] fetch_pc_o;
  logic        ireq_valid_o;
  logic [63:0] ireq_addr_o;
  logic        ireq_ready_i;
  logic        iresp_valid_i;
  logic [31:0] iresp_inst_i;
  logic        if_valid_o;
  logic [63:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic [63:0] rpc;
    logic [63:0] bpu;
    logic        rdy;
    logic        rv;
    logic [31:0] inst;
    logic        idr;
    logic        e_iv;
    logic [63:0] e_ia;
    logic        e_fv;
    logic [63:0] e_fpc;
    logic [31:0] e_finst;
    logic [63:0] e_fetch;
  } vec_t;

  vec_t vq[$];

  ysyx_22051013_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .bpu_pc_i(bpu_pc_i), .fetch_pc_o(fetch_pc_o), .ireq_valid_o(ireq_valid_o),
    .ireq_addr_o(ireq_addr_o), .ireq_ready_i(ireq_ready_i), .iresp_valid_i(iresp_valid_i),
    .iresp_inst_i(iresp_inst_i), .if_valid_o(if_valid_o), .if_pc_o(if_pc_o),
    .if_inst_o(if_inst_o), .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rd, input logic [63:0] rpc, input logic [63:0] bpu,
                              input logic rdy, input logic rv, input logic [31:0] inst, input logic idr,
                              input logic iv, input logic [63:0] ia, input logic fv,
                              input logic [63:0] fpc, input logic [31:0] finst, input logic [63:0] fetch);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.bpu = bpu; v.rdy = rdy; v.rv = rv; v.inst = inst; v.idr = idr;
    v.e_iv = iv; v.e_ia = ia; v.e_fv = fv; v.e_fpc = fpc; v.e_finst = finst; v.e_fetch = fetch;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    redirect_i = 1'b0; redirect_pc_i = 64'h0; bpu_pc_i = 64'h0; ireq_ready_i = 1'b0;
    iresp_valid_i = 1'b0; iresp_inst_i = 32'h0; id_ready_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

`ifdef YSYX_22051013_FETCH_SKID_EN
    // Two responses while decode stalls, then drained in order.
    vq.push_back(mk(0, 0, 0,          0, 0, 32'h0,        0, 0, P,          0, 64'h0,      32'h0,        P));
    vq.push_back(mk(0, 0, 0,          1, 0, 32'h0,        0, 1, P,          0, 64'h0,      32'h0,        P));
    vq.push_back(mk(0, 0, P+64'h4,    0, 1, 32'h00000013, 0, 0, P,          0, 64'h0,      32'h0,        P));
    vq.push_back(mk(0, 0, 0,          1, 0, 32'h0,        0, 1, P+64'h4,    1, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0, P+64'h8,    0, 1, 32'h00400093, 0, 0, P+64'h4,    1, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0, 0,          0, 0, 32'h0,        0, 0, P+64'h8,    1, P,          32'h00000013, P+64'h8));
    vq.push_back(mk(0, 0, 0,          0, 0, 32'h0,        0, 0, P+64'h8,    1, P,          32'h00000013, P+64'h8));
    vq.push_back(mk(0, 0, 0,          0, 0, 32'h0,        1, 0, P+64'h8,    1, P,          32'h00000013, P+64'h8));
    vq.push_back(mk(0, 0, 0,          0, 0, 32'h0,        1, 1, P+64'h8,    1, P+64'h4,    32'h00400093, P+64'h8));
    vq.push_back(mk(0, 0, 0,          0, 0, 32'h0,        0, 1, P+64'h8,    0, P+64'h4,    32'h00400093, P+64'h8));
`else
    // Fetch, stall in HOLD, redirect in REQ/WAIT/HOLD, last-wins, stray responses.
    vq.push_back(mk(0, 0,        0,        0, 0, 32'h0,        0, 0, P,          0, 64'h0,      32'h0,        P));
    vq.push_back(mk(0, 0,        0,        1, 0, 32'h0,        0, 1, P,          0, 64'h0,      32'h0,        P));
    vq.push_back(mk(0, 0,        P+64'h4,  0, 1, 32'h00000013, 0, 0, P,          0, 64'h0,      32'h0,        P));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(0, 0,      0,        0, 0, 32'h0,        0, 0, P+64'h4,    1, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0,        0,        0, 0, 32'h0,        1, 0, P+64'h4,    1, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(1, P+64'h100, 0,       0, 0, 32'h0,        0, 1, P+64'h4,    0, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0,        0,        0, 0, 32'h0,        0, 1, P+64'h4,    0, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0,        0,        0, 0, 32'h0,        0, 1, P+64'h4,    0, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0,        0,        1, 0, 32'h0,        0, 1, P+64'h4,    0, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0,        P+64'h8,  0, 1, 32'hDEADBEEF, 0, 0, P+64'h4,    0, P,          32'h00000013, P+64'h4));
    vq.push_back(mk(0, 0,        0,        1, 0, 32'h0,        0, 1, P+64'h100,  0, P,          32'h00000013, P+64'h100));
    vq.push_back(mk(1, P+64'h200, P+64'h104, 0, 1, 32'h11111111, 0, 0, P+64'h100, 0, P,        32'h00000013, P+64'h100));
    vq.push_back(mk(0, 0,        0,        1, 0, 32'h0,        0, 1, P+64'h200,  0, P,          32'h00000013, P+64'h200));
    vq.push_back(mk(0, 0,        0,        0, 0, 32'h0,        0, 0, P+64'h200,  0, P,          32'h00000013, P+64'h200));
    vq.push_back(mk(0, 0,        P+64'h204, 0, 1, 32'h00A00093, 0, 0, P+64'h200, 0, P,          32'h00000013, P+64'h200));
    vq.push_back(mk(1, P+64'h300, 0,       0, 0, 32'h0,        1, 0, P+64'h204,  0, P+64'h200,  32'h00A00093, P+64'h204));
    vq.push_back(mk(1, P+64'h400, 0,       0, 0, 32'h0,        0, 1, P+64'h300,  0, P+64'h200,  32'h00A00093, P+64'h300));
    vq.push_back(mk(1, P+64'h500, 0,       1, 0, 32'h0,        0, 1, P+64'h300,  0, P+64'h200,  32'h00A00093, P+64'h300));
    vq.push_back(mk(1, P+64'h600, 0,       0, 0, 32'h0,        0, 0, P+64'h300,  0, P+64'h200,  32'h00A00093, P+64'h300));
    vq.push_back(mk(0, 0,        P+64'h8,  0, 1, 32'hCAFEF00D, 0, 0, P+64'h300,  0, P+64'h200,  32'h00A00093, P+64'h300));
    vq.push_back(mk(0, 0,        0,        1, 0, 32'h0,        0, 1, P+64'h600,  0, P+64'h200,  32'h00A00093, P+64'h600));
    vq.push_back(mk(0, 0,        P+64'h604, 0, 1, 32'h00100073, 0, 0, P+64'h600, 0, P+64'h200,  32'h00A00093, P+64'h600));
    vq.push_back(mk(0, 0,        0,        0, 1, 32'hFFFFFFFF, 1, 0, P+64'h604,  1, P+64'h600,  32'h00100073, P+64'h604));
    vq.push_back(mk(0, 0,        0,        0, 1, 32'hFFFFFFFF, 0, 1, P+64'h604,  0, P+64'h600,  32'h00100073, P+64'h604));
    vq.push_back(mk(0, 0,        0,        0, 0, 32'h0,        0, 1, P+64'h604,  0, P+64'h600,  32'h00100073, P+64'h604));
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_ireq_valid", {63'h0, ireq_valid_o}, 64'h0);
    check("rst_ireq_addr", ireq_addr_o, P);
    check("rst_fetch_pc", fetch_pc_o, P);
    check("rst_if_valid", {63'h0, if_valid_o}, 64'h0);
    check("rst_if_pc", if_pc_o, 64'h0);
    check("rst_if_inst", {32'h0, if_inst_o}, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      redirect_i = vq[i].rd; redirect_pc_i = vq[i].rpc; bpu_pc_i = vq[i].bpu;
      ireq_ready_i = vq[i].rdy; iresp_valid_i = vq[i].rv; iresp_inst_i = vq[i].inst;
      id_ready_i = vq[i].idr;
      #3;
      check($sformatf("row%0d_ireq_valid", i), {63'h0, ireq_valid_o}, {63'h0, vq[i].e_iv});
      check($sformatf("row%0d_ireq_addr", i), ireq_addr_o, vq[i].e_ia);
      check($sformatf("row%0d_if_valid", i), {63'h0, if_valid_o}, {63'h0, vq[i].e_fv});
      check($sformatf("row%0d_if_pc", i), if_pc_o, vq[i].e_fpc);
      check($sformatf("row%0d_if_inst", i), {32'h0, if_inst_o}, {32'h0, vq[i].e_finst});
      check($sformatf("row%0d_fetch_pc", i), fetch_pc_o, vq[i].e_fetch);
    end

    // Reset mid-request, then a stray response while in IDLE/REQ must be ignored.
    @(posedge clk);
    #1;
    drive_idle();
    ireq_ready_i = 1'b1;
    @(posedge clk);
    #1;
    ireq_ready_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ireq_valid", {63'h0, ireq_valid_o}, 64'h0);
    check("arst_ireq_addr", ireq_addr_o, P);
    check("arst_fetch_pc", fetch_pc_o, P);
    check("arst_if_valid", {63'h0, if_valid_o}, 64'h0);
    check("arst_if_pc", if_pc_o, 64'h0);
    check("arst_if_inst", {32'h0, if_inst_o}, 64'h0);
    iresp_valid_i = 1'b1;
    iresp_inst_i  = 32'hDEADBEEF;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_idle_ireq_valid", {63'h0, ireq_valid_o}, 64'h1);
    check("post_idle_ireq_addr", ireq_addr_o, P);
    check("post_idle_if_valid", {63'h0, if_valid_o}, 64'h0);
    @(posedge clk);
    #1;
    check("post_req_ireq_valid", {63'h0, ireq_valid_o}, 64'h1);
    check("post_req_if_valid", {63'h0, if_valid_o}, 64'h0);
    iresp_valid_i = 1'b0;
    ireq_ready_i  = 1'b1;
    @(posedge clk);
    #1;
    ireq_ready_i  = 1'b0;
    iresp_valid_i = 1'b1;
    iresp_inst_i  = 32'h00000013;
    bpu_pc_i      = P + 64'h4;
    #1;
    check("post_wait_ireq_valid", {63'h0, ireq_valid_o}, 64'h0);
    @(posedge clk);
    #1;
    iresp_valid_i = 1'b0;
    #1;
    check("post_fetch_if_valid", {63'h0, if_valid_o}, 64'h1);
    check("post_fetch_if_pc", if_pc_o, P);
    check("post_fetch_if_inst", {32'h0, if_inst_o}, 64'h13);
    check("post_fetch_fetch_pc", fetch_pc_o, P + 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
